// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decoder with load-use stall detection and a HALT drain FSM.
// The ID/EX control word is registered; stall_o is the only combinational output.
module ctrl_decode_pipe #(
  parameter int NB_OP      = 6,
  parameter int NB_FUNCT   = 6,
  parameter int NB_REG     = 5,
  parameter int N_REGDEST  = 2,
  parameter int HALT_DRAIN = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [NB_OP-1:0]     opcode,
  input  logic [NB_FUNCT-1:0]  funct,
  input  logic [NB_REG-1:0]    rs,
  input  logic [NB_REG-1:0]    rt,
  input  logic                 ex_mem_read,
  input  logic [NB_REG-1:0]    ex_rt,
  input  logic                 flush_i,
  input  logic                 restart_i,
  output logic                 regWrite,
  output logic                 tipeI,
  output logic                 branch,
  output logic                 memWrite,
  output logic [N_REGDEST-1:0] regDest_signal,
  output logic [5:0]           mem_signals,
  output logic [2:0]           wb_signals,
  output logic [NB_OP-1:0]     opcode_o,
  output logic                 valid_o,
  output logic                 stall_o,
  output logic                 halted
);

  localparam logic [NB_OP-1:0]    OP_RTYPE = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0]    OP_ADDI  = NB_OP'(6'b001000);
  localparam logic [NB_OP-1:0]    OP_LW    = NB_OP'(6'b100011);
  localparam logic [NB_OP-1:0]    OP_LWU   = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0]    OP_LH    = NB_OP'(6'b100001);
  localparam logic [NB_OP-1:0]    OP_LB    = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0]    OP_SW    = NB_OP'(6'b101011);
  localparam logic [NB_OP-1:0]    OP_SH    = NB_OP'(6'b101001);
  localparam logic [NB_OP-1:0]    OP_SB    = NB_OP'(6'b101000);
  localparam logic [NB_OP-1:0]    OP_BEQ   = NB_OP'(6'b000100);
  localparam logic [NB_OP-1:0]    OP_BNE   = NB_OP'(6'b000101);
  localparam logic [NB_OP-1:0]    OP_NOP   = NB_OP'(6'b111110);
  localparam logic [NB_OP-1:0]    OP_HALT  = NB_OP'(6'b111111);
  localparam logic [NB_FUNCT-1:0] FN_JR    = NB_FUNCT'(6'b001000);
  localparam logic [NB_FUNCT-1:0] FN_JALR  = NB_FUNCT'(6'b001001);

  localparam logic [N_REGDEST-1:0] RD_RT = N_REGDEST'(2'b00);
  localparam logic [N_REGDEST-1:0] RD_RD = N_REGDEST'(2'b01);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       halted_n;

  logic                 d_reg_write, d_tipe_i, d_branch, d_mem_write, d_valid, d_uses_rt;
  logic [N_REGDEST-1:0] d_reg_dest;
  logic [5:0]           d_mem;
  logic [2:0]           d_wb;
  logic [NB_OP-1:0]     d_opcode;

  logic hazard, in_run, issue, halt_take;

  always_comb begin
    d_reg_write = 1'b0;
    d_tipe_i    = 1'b0;
    d_branch    = 1'b0;
    d_mem_write = 1'b0;
    d_reg_dest  = RD_RT;
    d_mem       = 6'b000000;
    d_wb        = 3'b000;
    d_valid     = 1'b1;
    d_opcode    = opcode;
    d_uses_rt   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_uses_rt = 1'b1;
        if (funct == FN_JR) begin
          d_branch = 1'b1;
        end else if (funct == FN_JALR) begin
          d_branch    = 1'b1;
          d_reg_write = 1'b1;
          d_reg_dest  = RD_RD;
          d_wb        = 3'b110;
        end else begin
          d_reg_write = 1'b1;
          d_reg_dest  = RD_RD;
          d_wb        = 3'b101;
        end
      end
      OP_ADDI: begin
        d_tipe_i    = 1'b1;
        d_reg_write = 1'b1;
        d_wb        = 3'b101;
      end
      OP_LW, OP_LWU, OP_LH, OP_LB: begin
        d_tipe_i    = 1'b1;
        d_reg_write = 1'b1;
        d_wb        = 3'b100;
        case (opcode)
          OP_LW:   d_mem = 6'b110100;
          OP_LWU:  d_mem = 6'b010100;
          OP_LH:   d_mem = 6'b110010;
          default: d_mem = 6'b110001;
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        d_tipe_i    = 1'b1;
        d_mem_write = 1'b1;
        d_uses_rt   = 1'b1;
        case (opcode)
          OP_SW:   d_mem = 6'b001100;
          OP_SH:   d_mem = 6'b001010;
          default: d_mem = 6'b001001;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        d_branch  = 1'b1;
        d_uses_rt = 1'b1;
      end
      OP_NOP: d_opcode = OP_NOP;
      // HALT and every unknown opcode register as a bubble
      default: begin
        d_valid  = 1'b0;
        d_opcode = OP_NOP;
      end
    endcase
  end

  assign in_run    = (state == S_RUN);
  assign hazard    = valid_i && ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == rs) || ((ex_rt == rt) && d_uses_rt));
  assign issue     = in_run && valid_i && !flush_i && !hazard;
  assign halt_take = issue && (opcode == OP_HALT);
  // A flush kills the instruction, so there is nothing left to stall for
  assign stall_o   = !reset && ((in_run && hazard && !flush_i) || (state == S_HALTED));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    halted_n = (state == S_HALTED) && !restart_i;
    case (state)
      S_RUN: begin
        if (halt_take) begin
          state_n = S_DRAIN;
          cnt_n   = 4'(HALT_DRAIN - 1);
        end
      end
      S_DRAIN: begin
        if (cnt == 4'd0) state_n = S_HALTED;
        else             cnt_n   = cnt - 4'd1;
      end
      S_HALTED: begin
        if (restart_i) state_n = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_RUN;
      cnt    <= 4'd0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      halted <= halted_n;
    end
  end

  // ID -> ID/EX boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regWrite       <= 1'b0;
      tipeI          <= 1'b0;
      branch         <= 1'b0;
      memWrite       <= 1'b0;
      regDest_signal <= RD_RT;
      mem_signals    <= 6'b000000;
      wb_signals     <= 3'b000;
      opcode_o       <= OP_NOP;
      valid_o        <= 1'b0;
    end else if (issue) begin
      regWrite       <= d_reg_write;
      tipeI          <= d_tipe_i;
      branch         <= d_branch;
      memWrite       <= d_mem_write;
      regDest_signal <= d_reg_dest;
      mem_signals    <= d_mem;
      wb_signals     <= d_wb;
      opcode_o       <= d_opcode;
      valid_o        <= d_valid;
    end else begin
      regWrite       <= 1'b0;
      tipeI          <= 1'b0;
      branch         <= 1'b0;
      memWrite       <= 1'b0;
      regDest_signal <= RD_RT;
      mem_signals    <= 6'b000000;
      wb_signals     <= 3'b000;
      opcode_o       <= OP_NOP;
      valid_o        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed testbench for ctrl_decode_pipe: decode table, load-use stall, flush,
// HALT drain/restart and asynchronous reset.
module tb_ctrl_decode_pipe;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       valid_i = 1'b0;
  logic [5:0] opcode = 6'b111110;
  logic [5:0] funct = 6'b000000;
  logic [4:0] rs = 5'd1;
  logic [4:0] rt = 5'd2;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rt = 5'd0;
  logic       flush_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       regWrite, tipeI, branch, memWrite, valid_o, stall_o, halted;
  logic [1:0] regDest_signal;
  logic [5:0] mem_signals, opcode_o;
  logic [2:0] wb_signals;

  int n_checks = 0;
  int n_fail   = 0;

  // {regWrite,tipeI,branch,memWrite, regDest, mem, wb, valid_o, opcode_o}
  logic [21:0] obs;
  assign obs = {regWrite, tipeI, branch, memWrite, regDest_signal, mem_signals,
                wb_signals, valid_o, opcode_o};

  localparam logic [21:0] BUBBLE  = {4'b0000, 2'b00, 6'b000000, 3'b000, 1'b0, 6'b111110};
  localparam logic [21:0] NOP_EXP = {4'b0000, 2'b00, 6'b000000, 3'b000, 1'b1, 6'b111110};
  localparam logic [21:0] LW_EXP  = {4'b1100, 2'b00, 6'b110100, 3'b100, 1'b1, 6'b100011};
  localparam logic [21:0] ADD_EXP = {4'b1000, 2'b01, 6'b000000, 3'b101, 1'b1, 6'b000000};

  localparam int NT = 11;
  logic [5:0]  t_op  [NT] = '{6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b100111,
                              6'b100001, 6'b101001, 6'b101000, 6'b000100, 6'b111110,
                              6'b010011};
  logic [5:0]  t_fn  [NT] = '{6'b100000, 6'b001000, 6'b001001, 6'b000000, 6'b000000,
                              6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                              6'b000000};
  logic [21:0] t_exp [NT] = '{
    {4'b1000, 2'b01, 6'b000000, 3'b101, 1'b1, 6'b000000},
    {4'b0010, 2'b00, 6'b000000, 3'b000, 1'b1, 6'b000000},
    {4'b1010, 2'b01, 6'b000000, 3'b110, 1'b1, 6'b000000},
    {4'b1100, 2'b00, 6'b000000, 3'b101, 1'b1, 6'b001000},
    {4'b1100, 2'b00, 6'b010100, 3'b100, 1'b1, 6'b100111},
    {4'b1100, 2'b00, 6'b110010, 3'b100, 1'b1, 6'b100001},
    {4'b0101, 2'b00, 6'b001010, 3'b000, 1'b1, 6'b101001},
    {4'b0101, 2'b00, 6'b001001, 3'b000, 1'b1, 6'b101000},
    {4'b0010, 2'b00, 6'b000000, 3'b000, 1'b1, 6'b000100},
    {4'b0000, 2'b00, 6'b000000, 3'b000, 1'b1, 6'b111110},
    {4'b0000, 2'b00, 6'b000000, 3'b000, 1'b0, 6'b111110}};

  ctrl_decode_pipe #(.NB_OP(6), .NB_FUNCT(6), .NB_REG(5), .N_REGDEST(2), .HALT_DRAIN(3)) dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush_i(flush_i),
    .restart_i(restart_i), .regWrite(regWrite), .tipeI(tipeI), .branch(branch),
    .memWrite(memWrite), .regDest_signal(regDest_signal), .mem_signals(mem_signals),
    .wb_signals(wb_signals), .opcode_o(opcode_o), .valid_o(valid_o), .stall_o(stall_o),
    .halted(halted));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] s, input logic [4:0] t);
    valid_i = v; opcode = op; funct = fn; rs = s; rt = t;
  endtask

  task automatic test_reset();
    set_instr(1'b1, 6'b100011, 6'b0, 5'd5, 5'd2);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== BUBBLE) begin n_fail++; $display("FAIL reset_outputs got %h expected %h", obs, BUBBLE); end
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b expected 0", stall_o); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b expected 0", halted); end
    step();
    n_checks++;
    if (obs !== BUBBLE) begin n_fail++; $display("FAIL reset_held got %h expected %h", obs, BUBBLE); end
    reset = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic test_lw();
    set_instr(1'b1, 6'b100011, 6'b0, 5'd1, 5'd2);
    step();
    n_checks++;
    if (obs !== LW_EXP) begin n_fail++; $display("FAIL lw_decode got %h expected %h", obs, LW_EXP); end
  endtask

  task automatic test_decode_table();
    for (int i = 0; i < NT; i++) begin
      set_instr(1'b1, t_op[i], t_fn[i], 5'd1, 5'd2);
      step();
      n_checks++;
      if (obs !== t_exp[i]) begin
        n_fail++; $display("FAIL decode[%0d] op=%b got %h expected %h", i, t_op[i], obs, t_exp[i]);
      end
    end
    set_instr(1'b0, 6'b100011, 6'b0, 5'd5, 5'd2);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL invalid_no_stall got %b expected 0", stall_o); end
    step();
    n_checks++;
    if (obs !== BUBBLE) begin n_fail++; $display("FAIL invalid_bubble got %h expected %h", obs, BUBBLE); end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic test_load_use();
    set_instr(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd5);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL hz_rt_stall got %b expected 1", stall_o); end
    step();
    n_checks++;
    if (obs !== BUBBLE) begin n_fail++; $display("FAIL hz_bubble got %h expected %h", obs, BUBBLE); end
    ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hz_one_cycle got %b expected 0", stall_o); end
    step();
    n_checks++;
    if (obs !== ADD_EXP) begin n_fail++; $display("FAIL hz_redecode got %h expected %h", obs, ADD_EXP); end
    ex_mem_read = 1'b1; ex_rt = 5'd0; rt = 5'd0;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hz_r0_stall got %b expected 0", stall_o); end
    step();
    n_checks++;
    if (obs !== ADD_EXP) begin n_fail++; $display("FAIL hz_r0_decode got %h expected %h", obs, ADD_EXP); end
    set_instr(1'b1, 6'b001000, 6'b0, 5'd1, 5'd7);
    ex_rt = 5'd7;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hz_addi_rt got %b expected 0", stall_o); end
    rs = 5'd7;
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL hz_addi_rs got %b expected 1", stall_o); end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    step();
  endtask

  task automatic test_flush();
    set_instr(1'b1, 6'b101011, 6'b0, 5'd1, 5'd5);
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL sw_stall got %b expected 1", stall_o); end
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b expected 0", stall_o); end
    step();
    n_checks++;
    if (obs !== BUBBLE) begin n_fail++; $display("FAIL flush_sw got %h expected %h", obs, BUBBLE); end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    set_instr(1'b1, 6'b111111, 6'b0, 5'd1, 5'd2);
    step();
    flush_i = 1'b0;
    set_instr(1'b1, 6'b111110, 6'b0, 5'd1, 5'd2);
    repeat (5) step();
    n_checks++;
    if ({halted, stall_o, obs} !== {2'b00, NOP_EXP}) begin
      n_fail++; $display("FAIL flush_halt halted=%b stall=%b obs=%h expected 0 0 %h", halted, stall_o, obs, NOP_EXP);
    end
  endtask

  task automatic test_halt();
    set_instr(1'b1, 6'b111111, 6'b0, 5'd1, 5'd2);
    step();
    n_checks++;
    if ({halted, obs} !== {1'b0, BUBBLE}) begin
      n_fail++; $display("FAIL halt_capture halted=%b obs=%h expected 0 %h", halted, obs, BUBBLE);
    end
    set_instr(1'b1, 6'b111110, 6'b0, 5'd1, 5'd2);
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if ({halted, valid_o} !== 2'b00) begin
        n_fail++; $display("FAIL drain_edge%0d halted=%b valid_o=%b expected 0 0", i, halted, valid_o);
      end
    end
    step();
    n_checks++;
    if ({halted, stall_o, valid_o} !== 3'b110) begin
      n_fail++; $display("FAIL halted_edge4 halted/stall/valid=%b expected 110", {halted, stall_o, valid_o});
    end
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    #1;
    n_checks++;
    if ({halted, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL restart halted/stall=%b expected 00", {halted, stall_o});
    end
    step();
    n_checks++;
    if (obs !== NOP_EXP) begin n_fail++; $display("FAIL restart_run got %h expected %h", obs, NOP_EXP); end
  endtask

  task automatic test_reset_async();
    set_instr(1'b1, 6'b111111, 6'b0, 5'd1, 5'd2);
    step();
    set_instr(1'b1, 6'b100011, 6'b0, 5'd1, 5'd2);
    step();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({halted, stall_o, obs} !== {2'b00, BUBBLE}) begin
      n_fail++; $display("FAIL drain_reset halted=%b stall=%b obs=%h expected 0 0 %h", halted, stall_o, obs, BUBBLE);
    end
    #1 reset = 1'b0;
    step();
    n_checks++;
    if (obs !== LW_EXP) begin n_fail++; $display("FAIL post_reset_lw got %h expected %h", obs, LW_EXP); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== BUBBLE) begin n_fail++; $display("FAIL async_clear got %h expected %h", obs, BUBBLE); end
    #1 reset = 1'b0;
    set_instr(1'b1, 6'b111111, 6'b0, 5'd1, 5'd2);
    step();
    set_instr(1'b1, 6'b111110, 6'b0, 5'd1, 5'd2);
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({halted, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL halted_reset halted/stall=%b expected 00", {halted, stall_o});
    end
    #1 reset = 1'b0;
    step();
    n_checks++;
    if (obs !== NOP_EXP) begin n_fail++; $display("FAIL halted_reset_run got %h expected %h", obs, NOP_EXP); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_decode_table();
    test_load_use();
    test_flush();
    test_halt();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
